hazard_forward_unit: RTL

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

---
 rtl/hazard_forward_unit_pkg.sv | 31 +++
 rtl/hazard_forward_unit_fwd_sel.sv | 26 ++
 rtl/hazard_forward_unit.sv | 101 ++++++++++
 3 files changed

// File: rtl/hazard_forward_unit_pkg.sv
// Shared types and constants for the hazard/forwarding unit: register address
// width, forwarding select encodings, pipeline shadow records.
package hazard_forward_unit_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b01;
  localparam logic [1:0] FWD_MEMWB   = 2'b10;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t rs1;
    reg_addr_t rs2;
    reg_addr_t rd;
    logic      regwrite;
    logic      memread;
  } ex_shadow_t;

  typedef struct packed {
    reg_addr_t rd;
    logic      regwrite;
  } wr_shadow_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd_sel.sv
// Forwarding select for one EX operand; the younger EX/MEM producer wins over
// MEM/WB, and x0 is never forwarded.
module hazard_fwd_sel
  import hazard_forward_unit_pkg::*;
(
  input  reg_addr_t  ex_rs,
  input  wr_shadow_t mem_stage,
  input  wr_shadow_t wb_stage,
  output logic       sel_s0,
  output logic       sel_s1
);

  logic [1:0] sel;

  always_comb begin
    sel = FWD_REGFILE;
    if (mem_stage.regwrite && (mem_stage.rd != REG_X0) && (mem_stage.rd == ex_rs))
      sel = FWD_EXMEM;
    else if (wb_stage.regwrite && (wb_stage.rd != REG_X0) && (wb_stage.rd == ex_rs))
      sel = FWD_MEMWB;
  end

  assign sel_s0 = sel[0];
  assign sel_s1 = sel[1];

endmodule

// File: rtl/hazard_forward_unit.sv
// Load-use stall, branch flush and operand forwarding driven from shadow copies
// of the EX/MEM/WB destination fields, plus saturating stall/flush counters.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  reg_addr_t   id_rs1,
  input  reg_addr_t   id_rs2,
  input  reg_addr_t   id_rd,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        ex_branch_taken,
  output logic        fwd_a_s0,
  output logic        fwd_a_s1,
  output logic        fwd_b_s0,
  output logic        fwd_b_s1,
  output logic        stall,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        flush,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cycles
);

  ex_shadow_t  ex_q, ex_d;
  wr_shadow_t  mem_q, mem_d;
  wr_shadow_t  wb_q, wb_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic a_s0, a_s1, b_s0, b_s1;

  assign load_use = ex_q.memread && (ex_q.rd != REG_X0) && id_valid &&
                    ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));

  // Flush outranks stall: the stalled instruction is being squashed anyway.
  assign flush      = !reset && ex_branch_taken;
  assign stall      = !reset && !ex_branch_taken && load_use;
  assign pc_write   = !stall;
  assign ifid_write = !stall;

  hazard_fwd_sel u_sel_a (
    .ex_rs     (ex_q.rs1),
    .mem_stage (mem_q),
    .wb_stage  (wb_q),
    .sel_s0    (a_s0),
    .sel_s1    (a_s1)
  );

  hazard_fwd_sel u_sel_b (
    .ex_rs     (ex_q.rs2),
    .mem_stage (mem_q),
    .wb_stage  (wb_q),
    .sel_s0    (b_s0),
    .sel_s1    (b_s1)
  );

  assign fwd_a_s0 = a_s0 && !reset;
  assign fwd_a_s1 = a_s1 && !reset;
  assign fwd_b_s0 = b_s0 && !reset;
  assign fwd_b_s1 = b_s1 && !reset;

  always_comb begin
    ex_d = '0;
    if (!flush && !stall && id_valid) begin
      ex_d.rs1      = id_rs1;
      ex_d.rs2      = id_rs2;
      ex_d.rd       = id_rd;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
    end
    mem_d.rd       = ex_q.rd;
    mem_d.regwrite = ex_q.regwrite;
    wb_d           = mem_q;
    stall_cnt_d    = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
    flush_cnt_d    = flush ? sat_inc(flush_cnt_q) : flush_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_cycles = flush_cnt_q;

endmodule
